// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the round-robin register-bank arbiter.
// Grant vectors are built at MAX_NREQ width and truncated by the user.
package dff_arb_pkg;

    localparam int MAX_NREQ = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits++;
            rem = rem >> 1;
        end
        return bits;
    endfunction

    function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx);
        return MAX_NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr,
// wrapping past the top requester back to index 0.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                idx   = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and write sequencer for a shared WIDTH-bit register.
// One grantee at a time writes its lane into q, optionally for a locked burst.
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        q,
    output logic                    wr_pulse,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);

    localparam int IW = clog2(NREQ);
    localparam int HW = clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_after;
    logic [HW-1:0]   hcnt;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            do_write;
    logic            extend;
    logic [WIDTH-1:0] lane_data;

    rr_pick #(
        .NREQ(NREQ),
        .IW  (IW)
    ) u_pick (
        .req  (req),
        .ptr  (ptr),
        .found(pick_found),
        .idx  (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pick_found) state_nxt = ST_GRANT;
            ST_GRANT: if (!extend)    state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Only the current owner's req/lock/lane matter while granted.
    always_comb begin
        busy      = (state != ST_IDLE);
        do_write  = (state == ST_GRANT) && req[owner];
        extend    = do_write && lock[owner] && (hcnt < HOLD_LAST);
        lane_data = wdata[owner*WIDTH +: WIDTH];
        ptr_after = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt      <= '0;
            q        <= '0;
            wr_pulse <= 1'b0;
            owner    <= '0;
            ptr      <= '0;
            hcnt     <= '0;
        end else begin
            wr_pulse <= do_write;
            if (do_write) begin
                q <= lane_data;
            end
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        gnt   <= NREQ'(onehot(32'(pick_idx)));
                        owner <= pick_idx;
                        hcnt  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (extend) begin
                        hcnt <= hcnt + HW'(1);
                    end else begin
                        gnt <= '0;
                        ptr <= ptr_after;
                    end
                end
                default: gnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed-vector bench for dff_bank_arbiter with hand-computed expectations.
module tb_dff_bank_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [7:0]  lane [4];
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        wr_pulse;
    logic [1:0]  owner;
    logic        busy;

    int checks = 0;
    int passes = 0;

    logic [7:0] rot_q [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    assign wdata = {lane[3], lane[2], lane[1], lane[0]};

    always #5 clk = ~clk;

    dff_bank_arbiter #(
        .NREQ    (4),
        .WIDTH   (8),
        .MAX_HOLD(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .lock    (lock),
        .wdata   (wdata),
        .gnt     (gnt),
        .q       (q),
        .wr_pulse(wr_pulse),
        .owner   (owner),
        .busy    (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l);
        req  = r;
        lock = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        reset = 1'b0;
        req   = 4'b1111;
        lock  = 4'b0000;
        lane  = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Held in reset with every requester asking: nothing may happen.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4'b1111, 4'b0000);
            checkOutput("rst_gnt",  gnt,      0);
            checkOutput("rst_q",    q,        0);
            checkOutput("rst_busy", busy,     0);
            checkOutput("rst_wr",   wr_pulse, 0);
            checkOutput("rst_own",  owner,    0);
        end

        reset = 1'b1;
        applyStimulus(4'b1111, 4'b0000);
        checkOutput("rel_gnt",  gnt,  4'b0001);
        checkOutput("rel_busy", busy, 1);

        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                applyStimulus(4'b1111, 4'b0000);
                checkOutput("rot_gnt", gnt,      32'(4'b0001 << (k % 4)));
                checkOutput("rot_wr0", wr_pulse, 0);
            end
            checkOutput("rot_own", owner, k % 4);
            applyStimulus(4'b1111, 4'b0000);
            checkOutput("rot_q",    q,        rot_q[k % 4]);
            checkOutput("rot_wr1",  wr_pulse, 1);
            checkOutput("rot_bub",  gnt,      0);
            checkOutput("rot_idle", busy,     0);
        end

        applyStimulus(4'b0000, 4'b0000);
        checkOutput("idle_gnt", gnt,      0);
        checkOutput("idle_wr",  wr_pulse, 0);
        checkOutput("idle_q",   q,        8'h44);

        lane[2] = 8'hA0;
        applyStimulus(4'b0100, 4'b0100);
        checkOutput("lk_gnt", gnt,   4'b0100);
        checkOutput("lk_own", owner, 2);
        for (int j = 0; j < 4; j++) begin
            lane[2] = 8'hA0 + 8'(j);
            applyStimulus(4'b0100, 4'b0100);
            checkOutput("lk_q",    q,        8'hA0 + j);
            checkOutput("lk_wr",   wr_pulse, 1);
            checkOutput("lk_hold", gnt,      (j < 3) ? 4'b0100 : 4'b0000);
            checkOutput("lk_busy", busy,     (j < 3) ? 1 : 0);
        end
        lane[2] = 8'hA4;
        applyStimulus(4'b0100, 4'b0100);
        checkOutput("lk_regnt", gnt,      4'b0100);
        checkOutput("lk_rg_wr", wr_pulse, 0);
        checkOutput("lk_rg_q",  q,        8'hA3);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("lk_drop_gnt", gnt,      0);
        checkOutput("lk_drop_q",   q,        8'hA3);
        checkOutput("lk_drop_wr",  wr_pulse, 0);

        // Pointer now sits at 3; requester 1 wins, then abandons its grant.
        applyStimulus(4'b0010, 4'b0000);
        checkOutput("er_gnt", gnt,   4'b0010);
        checkOutput("er_own", owner, 1);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("er_rel",  gnt,      0);
        checkOutput("er_wr",   wr_pulse, 0);
        checkOutput("er_q",    q,        8'hA3);
        checkOutput("er_busy", busy,     0);
        applyStimulus(4'b0011, 4'b0000);
        checkOutput("er_wrap", gnt,   4'b0001);
        checkOutput("er_own0", owner, 0);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("er_done", gnt, 0);

        // Move the pointer to 3 so a missing pointer reset would pick 3 later.
        applyStimulus(4'b0100, 4'b0000);
        checkOutput("mb_pre_gnt", gnt, 4'b0100);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("mb_pre_rel", gnt, 0);
        lane[3] = 8'h55;
        applyStimulus(4'b1000, 4'b1000);
        checkOutput("mb_gnt", gnt,   4'b1000);
        checkOutput("mb_own", owner, 3);
        applyStimulus(4'b1000, 4'b1000);
        checkOutput("mb_q1",   q,        8'h55);
        checkOutput("mb_wr1",  wr_pulse, 1);
        checkOutput("mb_hold", gnt,      4'b1000);
        lane[3] = 8'h66;
        reset   = 1'b0;
        applyStimulus(4'b1000, 4'b1000);
        checkOutput("mb_rst_q",    q,        0);
        checkOutput("mb_rst_gnt",  gnt,      0);
        checkOutput("mb_rst_own",  owner,    0);
        checkOutput("mb_rst_wr",   wr_pulse, 0);
        checkOutput("mb_rst_busy", busy,     0);
        reset = 1'b1;
        applyStimulus(4'b1010, 4'b0000);
        checkOutput("mb_ptr0_gnt", gnt,   4'b0010);
        checkOutput("mb_ptr0_own", owner, 1);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("mb_end_gnt", gnt, 0);
        checkOutput("mb_end_q",   q,   0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0000, 4'b0001);
            checkOutput("nolk_gnt",  gnt,  0);
            checkOutput("nolk_busy", busy, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
